// File: rtl/wb_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_timer_if
//  Description : Wishbone B4 classic bus bundle for the wb_timer slave.
//                master modport drives cyc/stb/we/adr/sel/dat_i and samples
//                dat_o/ack_o; slave modport is the mirror image.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_timer_if #(
  parameter int ADR_WIDTH = 5
);
  logic                 cyc_i;
  logic                 stb_i;
  logic                 we_i;
  logic [ADR_WIDTH-1:0] adr_i;
  logic [3:0]           sel_i;
  logic [31:0]          dat_i;
  logic [31:0]          dat_o;
  logic                 ack_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wb_timer
//  Description : Wishbone B4 classic slave holding a RISC-V style machine
//                timer (64-bit mtime, 64-bit mtimecmp, prescaler) and driving
//                the cpu machine timer interrupt as a registered level.
//  Ports       : clk_i             - clock
//                rst_ni            - asynchronous active-low reset
//                bus               - Wishbone slave (cyc/stb/we/adr/sel/dat)
//                timer_interrupt_o - level, high while mtime >= mtimecmp
//  Register map: 0x00 MTIME_LO, 0x04 MTIME_HI (shadow latched by LO read),
//                0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL (bit0 EN),
//                0x14 PRESCALE; other offsets read 0, writes ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_timer #(
  parameter int          ADR_WIDTH      = 5,
  parameter logic [31:0] PRESCALE_RESET = 32'h0
) (
  input  wire logic     clk_i,
  input  wire logic     rst_ni,
  wb_timer_if.slave     bus,
  output logic          timer_interrupt_o
);

  localparam int WW = ADR_WIDTH - 2;
  localparam logic [WW-1:0] c_OFF_MTIME_LO    = WW'(0);
  localparam logic [WW-1:0] c_OFF_MTIME_HI    = WW'(1);
  localparam logic [WW-1:0] c_OFF_MTIMECMP_LO = WW'(2);
  localparam logic [WW-1:0] c_OFF_MTIMECMP_HI = WW'(3);
  localparam logic [WW-1:0] c_OFF_CTRL        = WW'(4);
  localparam logic [WW-1:0] c_OFF_PRESCALE    = WW'(5);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_en;
  logic [31:0] r_prescale;
  logic [31:0] r_cnt;
  logic [31:0] r_shadow;
  logic        r_ack;
  logic [31:0] r_dat;

  logic [WW-1:0] w_word;
  logic          w_req;
  logic          w_wr;
  logic          w_rd;
  logic          w_tick;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // Byte-lane merge: only lanes with sel set take the new data.
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  assign w_word   = bus.adr_i[ADR_WIDTH-1:2];
  assign w_unused = ^bus.adr_i[1:0];

  // ~r_ack keeps a strobe held through the ack cycle from being acked twice.
  assign w_req  = bus.cyc_i & bus.stb_i & ~r_ack;
  assign w_wr   = w_req & bus.we_i;
  assign w_rd   = w_req & ~bus.we_i;
  assign w_tick = r_en && (r_cnt == r_prescale);

  always_comb begin
    w_rdata = 32'h0;
    case (w_word)
      c_OFF_MTIME_LO:    w_rdata = r_mtime[31:0];
      c_OFF_MTIME_HI:    w_rdata = r_shadow;
      c_OFF_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
      c_OFF_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
      c_OFF_CTRL:        w_rdata = {31'h0, r_en};
      c_OFF_PRESCALE:    w_rdata = r_prescale;
      default:           w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mtime           <= 64'h0;
      r_mtimecmp        <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_en              <= 1'b1;
      r_prescale        <= PRESCALE_RESET;
      r_cnt             <= 32'h0;
      r_shadow          <= 32'h0;
      r_ack             <= 1'b0;
      r_dat             <= 32'h0;
      timer_interrupt_o <= 1'b0;
    end else begin
      r_ack             <= w_req;
      r_dat             <= w_rd ? w_rdata : 32'h0;
      timer_interrupt_o <= (r_mtime >= r_mtimecmp);

      // Prescaler: a PRESCALE write restarts the count from zero.
      if (w_wr && (w_word == c_OFF_PRESCALE)) begin
        r_prescale <= f_merge(r_prescale, bus.dat_i, bus.sel_i);
        r_cnt      <= 32'h0;
      end else if (r_en) begin
        r_cnt <= w_tick ? 32'h0 : r_cnt + 32'h1;
      end

      // A bus write to either half suppresses the tick for the full 64 bits,
      // so no carry leaks into the half that was not written.
      if (w_wr && (w_word == c_OFF_MTIME_LO || w_word == c_OFF_MTIME_HI)) begin
        if (w_word == c_OFF_MTIME_LO)
          r_mtime[31:0]  <= f_merge(r_mtime[31:0], bus.dat_i, bus.sel_i);
        else
          r_mtime[63:32] <= f_merge(r_mtime[63:32], bus.dat_i, bus.sel_i);
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'h1;
      end

      if (w_wr && (w_word == c_OFF_MTIMECMP_LO))
        r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], bus.dat_i, bus.sel_i);
      if (w_wr && (w_word == c_OFF_MTIMECMP_HI))
        r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], bus.dat_i, bus.sel_i);

      if (w_wr && (w_word == c_OFF_CTRL) && bus.sel_i[0])
        r_en <= bus.dat_i[0];

      // Latching the upper half on a LO read makes a LO-then-HI read tear-free.
      if (w_rd && (w_word == c_OFF_MTIME_LO))
        r_shadow <= r_mtime[63:32];
    end
  end

  assign bus.ack_o = r_ack;
  assign bus.dat_o = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_wb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_timer
//  Description : Self-checking bench for wb_timer. mtime is predicted from
//                an anchor value plus the number of prescaler periods elapsed
//                since the last prescaler restart (plain integer division).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_timer;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic timer_interrupt_o;

  wb_timer_if #(.ADR_WIDTH(5)) bus ();

  wb_timer #(.ADR_WIDTH(5), .PRESCALE_RESET(32'h0)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .bus               (bus.slave),
    .timer_interrupt_o (timer_interrupt_o)
  );

  always #5 clk_i = ~clk_i;

  int edge_n = 0;
  always @(posedge clk_i) edge_n <= edge_n + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_en;
  longint      m_e0;      // edge at which the prescaler count was zero
  longint      m_wv;      // edge after which mtime equalled m_v
  longint      m_p;
  bit [63:0]   m_v;
  bit [63:0]   m_cmp;
  bit [31:0]   m_shadow;

  function automatic bit [63:0] val_after(longint k);
    longint d;
    if (!m_en) return m_v;
    d = (k - m_e0) / (m_p + 1) - (m_wv - m_e0) / (m_p + 1);
    return m_v + 64'(d);
  endfunction

  function automatic bit [31:0] mrg(bit [31:0] o, bit [31:0] n, bit [3:0] s);
    bit [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset(longint k);
    m_en = 1'b1; m_e0 = k; m_wv = k; m_p = 0;
    m_v = 64'h0; m_cmp = '1; m_shadow = 32'h0;
  endtask

  function automatic bit [31:0] exp_read(longint r, bit [4:0] off);
    bit [63:0] cur;
    cur = val_after(r - 1);
    case (off)
      5'h00:   return cur[31:0];
      5'h04:   return m_shadow;
      5'h08:   return m_cmp[31:0];
      5'h0C:   return m_cmp[63:32];
      5'h10:   return {31'h0, m_en};
      5'h14:   return m_p[31:0];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(longint w, bit [4:0] off, bit [3:0] sel, bit [31:0] d);
    bit [63:0] cur;
    case (off)
      5'h00: begin cur = val_after(w - 1); m_v = {cur[63:32], mrg(cur[31:0], d, sel)}; m_wv = w; end
      5'h04: begin cur = val_after(w - 1); m_v = {mrg(cur[63:32], d, sel), cur[31:0]}; m_wv = w; end
      5'h08: m_cmp[31:0]  = mrg(m_cmp[31:0], d, sel);
      5'h0C: m_cmp[63:32] = mrg(m_cmp[63:32], d, sel);
      5'h10: if (sel[0]) begin
        cur = val_after(w); m_v = cur; m_wv = w;
        if (!m_en && d[0]) m_e0 = w;
        m_en = d[0];
      end
      5'h14: begin
        cur = val_after(w); m_v = cur; m_wv = w; m_e0 = w;
        m_p = longint'(mrg(m_p[31:0], d, sel));
      end
      default: ;
    endcase
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One Wishbone transfer; checks ack timing, data, interrupt at both edges.
  task automatic xfer(bit we, bit [4:0] adr, bit [3:0] sel, bit [31:0] d,
                      string tag, output bit [31:0] rd);
    longint    w;
    bit [63:0] cur;
    bit [4:0]  off;
    off = {adr[4:2], 2'b00};
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
    bus.adr_i = adr; bus.sel_i = sel; bus.dat_i = d;
    @(posedge clk_i); #1;
    w = longint'(edge_n);
    cur = val_after(w - 1);
    check({tag, " ack"}, bus.ack_o, 1'b1);
    check({tag, " irq@ack"}, timer_interrupt_o, cur >= m_cmp);
    if (!we) begin
      check({tag, " rdata"}, bus.dat_o, exp_read(w, off));
      if (off == 5'h00) m_shadow = cur[63:32];
    end else begin
      check({tag, " wdata_o"}, bus.dat_o, 32'h0);
      model_write(w, off, sel, d);
    end
    rd = bus.dat_o;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    @(posedge clk_i); #1;
    cur = val_after(w);
    check({tag, " ack drop"}, bus.ack_o, 1'b0);
    check({tag, " dat idle"}, bus.dat_o, 32'h0);
    check({tag, " irq@ack+1"}, timer_interrupt_o, cur >= m_cmp);
  endtask

  task automatic poll(int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      check("irq poll", timer_interrupt_o, val_after(longint'(edge_n) - 1) >= m_cmp);
    end
  endtask

  bit [31:0] rd, lo, hi;
  int        p;

  initial begin
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    bus.adr_i = '0; bus.sel_i = 4'h0; bus.dat_i = 32'h0;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    check("rst ack", bus.ack_o, 1'b0);
    check("rst dat", bus.dat_o, 32'h0);
    check("rst irq", timer_interrupt_o, 1'b0);
    rst_ni = 1'b1;
    model_reset(longint'(edge_n));
    for (int a = 0; a < 8; a++) xfer(1'b0, 5'(a * 4), 4'hF, 32'h0, "reset read", rd);

    // Randomized counting, prescaler and snapshot reads
    for (int it = 0; it < 6; it++) begin
      xfer(1'b1, 5'h10, 4'hF, 32'h0, "ctrl off", rd);
      lo = (it % 2 == 1) ? 32'hFFFF_FFFF - $urandom_range(0, 30) : $urandom;
      hi = (it == 2) ? 32'hFFFF_FFFF : $urandom;
      p  = (it == 0) ? 3 : int'($urandom_range(0, 4));
      if (it == 3) begin lo = 32'hFFFF_FFFF; hi = 32'h0; p = 0; end
      xfer(1'b1, 5'h00, 4'hF, lo, "mtime lo wr", rd);
      xfer(1'b1, 5'h04, 4'hF, hi, "mtime hi wr", rd);
      xfer(1'b1, 5'h14, 4'hF, 32'(p), "presc wr", rd);
      xfer(1'b1, 5'h10, 4'hF, 32'h1, "ctrl on", rd);
      poll((it == 0) ? 40 : int'($urandom_range(0, 40)));
      xfer(1'b0, 5'h00, 4'hF, 32'h0, "snap lo", rd);
      poll(5);
      xfer(1'b0, 5'h04, 4'hF, 32'h0, "snap hi", rd);
      xfer(1'b0, 5'h00, 4'hF, 32'h0, "snap lo2", rd);
      if ($urandom_range(0, 1) == 1)
        xfer(1'b1, 5'h04, 4'(  $urandom_range(0, 15)), $urandom, "hi wr running", rd);
      xfer(1'b1, 5'h00, 4'h1, $urandom, "lo byte wr running", rd);
      xfer(1'b1, 5'h14, 4'hF, 32'(p), "presc rewr", rd);
      poll(int'($urandom_range(0, 6)));
      xfer(1'b0, 5'h00, 4'hF, 32'h0, "tick lo a", rd);
      xfer(1'b0, 5'h00, 4'hF, 32'h0, "tick lo b", rd);
      xfer(1'b0, 5'h10, 4'hF, 32'h0, "ctrl rd", rd);
      xfer(1'b0, 5'h14, 4'hF, 32'h0, "presc rd", rd);
    end

    // Interrupt rise at mtime == mtimecmp and fall on mtimecmp raise
    xfer(1'b1, 5'h10, 4'hF, 32'h0, "irq ctrl off", rd);
    xfer(1'b1, 5'h0C, 4'hF, 32'h0, "irq cmp hi", rd);
    xfer(1'b1, 5'h08, 4'hF, 32'd100, "irq cmp lo", rd);
    xfer(1'b1, 5'h00, 4'hF, 32'd90, "irq mtime lo", rd);
    xfer(1'b1, 5'h04, 4'hF, 32'h0, "irq mtime hi", rd);
    xfer(1'b1, 5'h14, 4'hF, 32'h0, "irq presc", rd);
    xfer(1'b1, 5'h10, 4'hF, 32'h1, "irq ctrl on", rd);
    poll(20);
    check("irq high after cmp reached", timer_interrupt_o, 1'b1);
    xfer(1'b1, 5'h08, 4'hF, 32'd1000, "irq cmp raise", rd);
    poll(3);

    // Byte enables and unmapped offsets
    xfer(1'b1, 5'h08, 4'hF, 32'hFFFF_FFFF, "cmp lo full", rd);
    xfer(1'b1, 5'h08, 4'b0010, 32'h0000_AB00, "cmp lo byte1", rd);
    xfer(1'b0, 5'h08, 4'hF, 32'h0, "cmp lo rd", rd);
    check("cmp lo byte value", rd, 32'hFFFF_ABFF);
    xfer(1'b1, 5'h08, 4'h0, 32'h1234_5678, "cmp lo sel0", rd);
    xfer(1'b0, 5'h08, 4'hF, 32'h0, "cmp lo rd2", rd);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 5'h0C, 4'($urandom_range(0, 15)), $urandom, "cmp hi rnd", rd);
      xfer(1'b0, 5'h0C, 4'hF, 32'h0, "cmp hi rnd rd", rd);
    end
    xfer(1'b1, 5'h18, 4'hF, $urandom, "unmapped wr", rd);
    xfer(1'b0, 5'h18, 4'hF, 32'h0, "unmapped rd", rd);
    xfer(1'b0, 5'h1F, 4'hF, 32'h0, "unmapped rd2", rd);

    // Asynchronous reset in the middle of a transfer
    xfer(1'b1, 5'h08, 4'hF, 32'h0, "pre-rst cmp lo", rd);
    xfer(1'b1, 5'h0C, 4'hF, 32'h0, "pre-rst cmp hi", rd);
    xfer(1'b1, 5'h00, 4'hF, 32'h5, "pre-rst mtime", rd);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
    bus.adr_i = 5'h00; bus.sel_i = 4'hF;
    @(posedge clk_i); #1;
    check("mid ack", bus.ack_o, 1'b1);
    check("mid rdata", bus.dat_o, exp_read(longint'(edge_n), 5'h00));
    check("mid irq", timer_interrupt_o, 1'b1);
    bus.we_i = 1'b1; bus.adr_i = 5'h08; bus.dat_i = 32'h55;
    #2 rst_ni = 1'b0;
    #1;
    check("async rst ack", bus.ack_o, 1'b0);
    check("async rst dat", bus.dat_o, 32'h0);
    check("async rst irq", timer_interrupt_o, 1'b0);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset(longint'(edge_n));
    xfer(1'b0, 5'h08, 4'hF, 32'h0, "post-rst cmp lo", rd);
    check("post-rst cmp lo value", rd, 32'hFFFF_FFFF);
    xfer(1'b0, 5'h10, 4'hF, 32'h0, "post-rst ctrl", rd);
    xfer(1'b0, 5'h00, 4'hF, 32'h0, "post-rst mtime", rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
